// File: rtl/phy_len_pkg.sv
// Shared constants for the PHY length calculator: FSM encoding, rate codes and the N_DBPS table.
package phy_len_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_DIV    = 2'd2;
  localparam logic [1:0] ST_FIX    = 2'd3;

  localparam int DBPS_TBL_W = 11;
  localparam int DBPS_MAX   = 1080;

  localparam logic [3:0] RATE_6M  = 4'hB;
  localparam logic [3:0] RATE_9M  = 4'hF;
  localparam logic [3:0] RATE_12M = 4'hA;
  localparam logic [3:0] RATE_18M = 4'hE;
  localparam logic [3:0] RATE_24M = 4'h9;
  localparam logic [3:0] RATE_36M = 4'hD;
  localparam logic [3:0] RATE_48M = 4'h8;
  localparam logic [3:0] RATE_54M = 4'hC;

  typedef logic [DBPS_TBL_W-1:0] dbps_t;

  // Returns 0 for any code without a table entry.
  function automatic dbps_t dbps_lookup(input logic ht, input logic bw40, input logic [3:0] code);
    dbps_t base;
    base = '0;
    if (!ht) begin
      case (code)
        RATE_6M:  base = 11'd24;
        RATE_9M:  base = 11'd36;
        RATE_12M: base = 11'd48;
        RATE_18M: base = 11'd72;
        RATE_24M: base = 11'd96;
        RATE_36M: base = 11'd144;
        RATE_48M: base = 11'd192;
        RATE_54M: base = 11'd216;
        default:  base = '0;
      endcase
    end else begin
      case (code[2:0])
        3'd0:    base = bw40 ? 11'd54  : 11'd26;
        3'd1:    base = bw40 ? 11'd108 : 11'd52;
        3'd2:    base = bw40 ? 11'd162 : 11'd78;
        3'd3:    base = bw40 ? 11'd216 : 11'd104;
        3'd4:    base = bw40 ? 11'd324 : 11'd156;
        3'd5:    base = bw40 ? 11'd432 : 11'd208;
        3'd6:    base = bw40 ? 11'd486 : 11'd234;
        default: base = bw40 ? 11'd540 : 11'd260;
      endcase
      if (code[3]) base = base << 1;
    end
    return base;
  endfunction

endpackage

// File: rtl/seq_restoring_div.sv
// Radix-2 restoring divider; the first quotient bit is resolved on the start edge so
// done pulses exactly NUM_W cycles after start. Results hold until the next start.
module seq_restoring_div #(
  parameter int NUM_W = 20,
  parameter int DEN_W = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W-1:0] remainder
);

  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [NUM_W-1:0] trial_quo, step_quo;
  logic [DEN_W-1:0] trial_rem, trial_den, step_rem;
  logic [DEN_W:0]   partial;

  always_comb begin
    trial_rem = start ? '0  : rem_q;
    trial_quo = start ? num : quo_q;
    trial_den = start ? den : den_q;
    partial   = {trial_rem, trial_quo[NUM_W-1]};
    if (partial >= {1'b0, trial_den}) begin
      step_rem = DEN_W'(partial - {1'b0, trial_den});
      step_quo = {trial_quo[NUM_W-2:0], 1'b1};
    end else begin
      step_rem = partial[DEN_W-1:0];
      step_quo = {trial_quo[NUM_W-2:0], 1'b0};
    end

    quo_d  = quo_q;
    rem_d  = rem_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      quo_d  = step_quo;
      rem_d  = step_rem;
      den_d  = den;
      cnt_d  = CNT_LOAD;
      done_d = (NUM_W == 1);
    end else if (cnt_q != '0) begin
      quo_d  = step_quo;
      rem_d  = step_rem;
      cnt_d  = cnt_q - CNT_ONE;
      done_d = (cnt_q == CNT_ONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/phy_len_calc_mimo.sv
// OFDM symbol count and last-symbol bit count from SIG length for non-HT/HT20/HT40, MCS 0-15.
// start -> done in BITS_W+3 cycles (2 for an unknown rate); start ignored while busy, abort cancels.
module phy_len_calc_mimo
  import phy_len_pkg::*;
#(
  parameter int BITS_W   = 20,
  parameter int SYM_W    = 15,
  parameter int DBPS_W   = 11,
  parameter int LAST_RST = 130
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [BITS_W-1:0] num_bits_to_decode,
  input  logic [7:0]        pkt_rate,
  input  logic              ht_bw40,
  output logic              busy,
  output logic              done,
  output logic [SYM_W-1:0]  n_ofdm_sym,
  output logic [BITS_W-1:0] n_bit_in_last_sym,
  output logic [DBPS_W-1:0] n_dbps,
  output logic              phy_len_valid,
  output logic              rate_err,
  output logic              sym_sat
);

  localparam logic [SYM_W-1:0]  SYM_MAX     = '1;
  localparam logic [BITS_W:0]   SYM_MAX_EXT = {{(BITS_W + 1 - SYM_W){1'b0}}, SYM_MAX};
  localparam logic [BITS_W:0]   ONE_EXT     = (BITS_W + 1)'(1);

  logic [1:0]        state_q, state_d;
  logic [BITS_W-1:0] num_q, num_d;
  logic              ht_q, ht_d;
  logic [3:0]        code_q, code_d;
  logic              bw40_q, bw40_d;
  logic [DBPS_W-1:0] dbps_q, dbps_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [BITS_W-1:0] last_q, last_d;
  logic              valid_q, valid_d;
  logic              rate_err_q, rate_err_d;
  logic              sym_sat_q, sym_sat_d;
  logic              done_q, done_d;

  logic              div_start, div_done;
  logic [BITS_W-1:0] div_quo;
  logic [DBPS_W-1:0] div_rem;
  logic [DBPS_W-1:0] lut_dbps;
  logic              exact;
  logic [BITS_W:0]   sym_full;
  logic              sym_over;

  seq_restoring_div #(
    .NUM_W(BITS_W),
    .DEN_W(DBPS_W)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .num      (num_q),
    .den      (lut_dbps),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign lut_dbps = DBPS_W'(dbps_lookup(ht_q, bw40_q, code_q));

  // An exact multiple fills the last symbol; zero length still occupies one symbol.
  assign exact    = (div_rem == '0) && (num_q != '0);
  assign sym_full = exact ? {1'b0, div_quo} : {1'b0, div_quo} + ONE_EXT;
  assign sym_over = sym_full > SYM_MAX_EXT;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    ht_d       = ht_q;
    code_d     = code_q;
    bw40_d     = bw40_q;
    dbps_d     = dbps_q;
    sym_d      = sym_q;
    last_d     = last_q;
    valid_d    = valid_q;
    rate_err_d = rate_err_q;
    sym_sat_d  = sym_sat_q;
    done_d     = 1'b0;
    div_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          num_d      = num_bits_to_decode;
          ht_d       = pkt_rate[7];
          code_d     = pkt_rate[3:0];
          bw40_d     = ht_bw40;
          valid_d    = 1'b0;
          rate_err_d = 1'b0;
          sym_sat_d  = 1'b0;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          dbps_d = lut_dbps;
          if (lut_dbps == '0) begin
            rate_err_d = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (div_done) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          sym_d     = sym_over ? SYM_MAX : sym_full[SYM_W-1:0];
          sym_sat_d = sym_over;
          last_d    = exact ? BITS_W'(dbps_q) : BITS_W'(div_rem);
          valid_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      ht_q       <= 1'b0;
      code_q     <= '0;
      bw40_q     <= 1'b0;
      dbps_q     <= '0;
      sym_q      <= SYM_W'(1);
      last_q     <= BITS_W'(LAST_RST);
      valid_q    <= 1'b0;
      rate_err_q <= 1'b0;
      sym_sat_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      ht_q       <= ht_d;
      code_q     <= code_d;
      bw40_q     <= bw40_d;
      dbps_q     <= dbps_d;
      sym_q      <= sym_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      rate_err_q <= rate_err_d;
      sym_sat_q  <= sym_sat_d;
      done_q     <= done_d;
    end
  end

  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign n_ofdm_sym        = sym_q;
  assign n_bit_in_last_sym = last_q;
  assign n_dbps            = dbps_q;
  assign phy_len_valid     = valid_q;
  assign rate_err          = rate_err_q;
  assign sym_sat           = sym_sat_q;

endmodule

// File: tb/tb_phy_len_calc_mimo.sv
// Scoreboard bench for phy_len_calc_mimo: driver pushes model results, monitor checks each done pulse.
module tb_phy_len_calc_mimo;

  localparam int BITS_W   = 20;
  localparam int SYM_W    = 15;
  localparam int DBPS_W   = 11;
  localparam int LAST_RST = 130;
  localparam int SYM_MAX  = (1 << SYM_W) - 1;
  localparam int NUM_MAX  = (1 << BITS_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [BITS_W-1:0] num_bits = '0;
  logic [7:0]        pkt_rate = '0;
  logic              ht_bw40 = 1'b0;
  logic              busy, done, phy_len_valid, rate_err, sym_sat;
  logic [SYM_W-1:0]  n_ofdm_sym;
  logic [BITS_W-1:0] n_bit_in_last_sym;
  logic [DBPS_W-1:0] n_dbps;

  phy_len_calc_mimo #(
    .BITS_W(BITS_W), .SYM_W(SYM_W), .DBPS_W(DBPS_W), .LAST_RST(LAST_RST)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .num_bits_to_decode(num_bits), .pkt_rate(pkt_rate), .ht_bw40(ht_bw40),
    .busy(busy), .done(done), .n_ofdm_sym(n_ofdm_sym), .n_bit_in_last_sym(n_bit_in_last_sym),
    .n_dbps(n_dbps), .phy_len_valid(phy_len_valid), .rate_err(rate_err), .sym_sat(sym_sat)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int sym; int lst; int dbps; bit valid; bit err; bit sat; int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int prev_sym  = 1;
  int prev_last = LAST_RST;

  // N_DBPS by L-SIG rate code (index = code), and by HT MCS 0-7.
  int nonht_tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 192, 96, 48, 24, 216, 144, 72, 36};
  int ht20_tbl[8]   = '{26, 52, 78, 104, 156, 208, 234, 260};
  int ht40_tbl[8]   = '{54, 108, 162, 216, 324, 432, 486, 540};

  function automatic int ref_dbps(bit [7:0] r, bit bw);
    int m;
    m = int'(r[3:0]);
    if (!r[7]) return nonht_tbl[m];
    return (bw ? ht40_tbl[m % 8] : ht20_tbl[m % 8]) * ((m >= 8) ? 2 : 1);
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_sym"},   n_ofdm_sym, 1);
    chk({tag, "_last"},  n_bit_in_last_sym, LAST_RST);
    chk({tag, "_dbps"},  n_dbps, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_valid"}, phy_len_valid, 0);
    chk({tag, "_rerr"},  rate_err, 0);
    chk({tag, "_sat"},   sym_sat, 0);
  endtask

  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("n_ofdm_sym", n_ofdm_sym, mon_e.sym);
        chk("n_bit_in_last_sym", n_bit_in_last_sym, mon_e.lst);
        chk("n_dbps", n_dbps, mon_e.dbps);
        chk("phy_len_valid", phy_len_valid, mon_e.valid);
        chk("rate_err", rate_err, mon_e.err);
        chk("sym_sat", sym_sat, mon_e.sat);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic issue(int n, bit [7:0] r, bit bw, bit overlap);
    exp_t e;
    int d, q, rr, s;
    @(negedge clock);
    num_bits = BITS_W'(n);
    pkt_rate = r;
    ht_bw40  = bw;
    start    = 1'b1;
    @(posedge clock);
    #1;
    d = ref_dbps(r, bw);
    e.dbps = d;
    if (d == 0) begin
      e.err = 1; e.valid = 0; e.sat = 0;
      e.sym = prev_sym; e.lst = prev_last;
      e.cyc = cyc + 1;
    end else begin
      q  = n / d;
      rr = n % d;
      if (rr == 0 && n != 0) begin s = q; e.lst = d; end
      else begin s = q + 1; e.lst = rr; end
      e.sat = (s > SYM_MAX);
      e.sym = e.sat ? SYM_MAX : s;
      e.err = 0; e.valid = 1;
      e.cyc = cyc + BITS_W + 2;
      prev_sym  = e.sym;
      prev_last = e.lst;
    end
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    num_bits = BITS_W'($urandom);
    pkt_rate = 8'($urandom);
    ht_bw40  = 1'($urandom);
    if (overlap && d != 0) begin
      repeat ($urandom_range(1, 10)) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit [7:0] r;
    bit       bw;
    int       n, d;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b0;

    // unknown rate straight after reset keeps the reset estimate
    issue(822, 8'h05, 1'b0, 1'b0);
    issue(822, 8'h0B, 1'b0, 1'b0);
    chk("tp_6m_sym", n_ofdm_sym, 35);
    chk("tp_6m_last", n_bit_in_last_sym, 6);
    issue(260, 8'h87, 1'b0, 1'b0);
    issue(520, 8'h87, 1'b0, 1'b0);
    chk("tp_ht20_sym", n_ofdm_sym, 2);
    chk("tp_ht20_last", n_bit_in_last_sym, 260);
    issue(2182, 8'h8F, 1'b1, 1'b0);
    chk("tp_ht40_dbps", n_dbps, 1080);
    chk("tp_ht40_last", n_bit_in_last_sym, 22);
    issue(524302, 8'h80, 1'b0, 1'b0);
    chk("tp_mcs0_sym", n_ofdm_sym, 20166);
    issue(NUM_MAX, 8'h0B, 1'b0, 1'b0);
    chk("tp_sat_sym", n_ofdm_sym, 32767);
    chk("tp_sat_flag", sym_sat, 1);
    chk("tp_sat_last", n_bit_in_last_sym, 15);
    issue(0, 8'h0B, 1'b0, 1'b0);
    issue(1000, 8'h0D, 1'b0, 1'b1);

    // start together with abort in IDLE is dropped and leaves valid results alone
    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_valid", phy_len_valid, 1);

    // abort in the fifth DIV cycle
    @(negedge clock);
    num_bits = BITS_W'(5000); pkt_rate = 8'h0B; start = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", phy_len_valid, 0);
    chk("abort_sym_kept", n_ofdm_sym, prev_sym);
    chk("abort_last_kept", n_bit_in_last_sym, prev_last);
    repeat (30) @(negedge clock);

    // reset in the middle of a calculation
    @(negedge clock);
    num_bits = BITS_W'(7777); pkt_rate = 8'h83; ht_bw40 = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_vals("midreset");
    reset = 1'b0;
    prev_sym  = 1;
    prev_last = LAST_RST;
    repeat (30) @(negedge clock);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) r = {1'b1, 3'($urandom), 4'($urandom)};
      else                           r = {1'b0, 3'($urandom), 4'($urandom)};
      bw = 1'($urandom);
      d  = ref_dbps(r, bw);
      case ($urandom_range(0, 3))
        0:       n = int'($urandom_range(0, NUM_MAX));
        1:       n = int'($urandom_range(0, 3000));
        2:       n = (d == 0) ? 100 : d * int'($urandom_range(1, 900));
        default: n = NUM_MAX - int'($urandom_range(0, 50000));
      endcase
      issue(n, r, bw, 1'($urandom));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phy_len_calc_mimo.md
Name: phy_len_calc_mimo

Overview:
- Parametrised successor to the receiver's PHY length calculator.
- Computes the OFDM symbol count and the number of data bits in the last symbol from the decoded SIG length. The decoder uses these for latency prediction and end-of-packet timing.
- Covers non-HT, HT20 and HT40 with 1 or 2 spatial streams (MCS 0-15).
- Uses a fixed-latency sequential divider instead of open-ended repeated subtraction, and adds a start/busy/done handshake, abort, saturation and invalid-rate reporting.

Parameters:
- BITS_W, 20, width of num_bits_to_decode.
- SYM_W, 15, width of n_ofdm_sym; the result saturates at 2^SYM_W-1.
- DBPS_W, 11, width of N_DBPS; the maximum value is 1080 (HT40, MCS15).
- LAST_RST, 130, reset value of n_bit_in_last_sym (mid-point estimate used before any calculation).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only when busy=0.
- abort  in  1  cancels any calculation in progress.
- num_bits_to_decode  in  BITS_W  SERVICE+PSDU+tail bit count.
- pkt_rate  in  8  bit7: 1=HT, 0=non-HT; bits[3:0]: L-SIG rate code (non-HT) or MCS (HT).
- ht_bw40  in  1  HT only: 1 selects 40 MHz N_DBPS; ignored for non-HT.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results update.
- n_ofdm_sym  out  SYM_W  symbol count.
- n_bit_in_last_sym  out  BITS_W  bits in the final symbol.
- n_dbps  out  DBPS_W  N_DBPS used for the calculation.
- phy_len_valid  out  1  level; results valid, held until the next accepted start.
- rate_err  out  1  level; the latched rate has no N_DBPS entry.
- sym_sat  out  1  level; n_ofdm_sym was clamped.

Behaviour:
- Reset values:
  - n_ofdm_sym=1, n_bit_in_last_sym=LAST_RST.
  - n_dbps, busy, done, phy_len_valid, rate_err, sym_sat = 0.
  - FSM in IDLE.
- FSM states: IDLE, LOOKUP, DIV, FIX.
- IDLE:
  - start=1 and abort=0: latch num_bits, pkt_rate and ht_bw40; clear phy_len_valid, rate_err and sym_sat; go to LOOKUP.
  - start while busy is ignored.
  - start together with abort in IDLE: abort wins, nothing is latched.
- LOOKUP, 1 cycle: register N_DBPS from the table.
  - Non-HT codes: 0xB=24, 0xF=36, 0xA=48, 0xE=72, 0x9=96, 0xD=144, 0x8=192, 0xC=216.
  - HT20, MCS0-7: 26, 52, 78, 104, 156, 208, 234, 260.
  - HT40, MCS0-7: 54, 108, 162, 216, 324, 432, 486, 540.
  - MCS8-15: twice the value for MCS-8.
  - Any other code gives 0. On 0: set rate_err=1, pulse done, phy_len_valid stays 0, leave n_ofdm_sym and n_bit_in_last_sym unchanged, return to IDLE.
  - Otherwise go to DIV.
- DIV, exactly BITS_W cycles: radix-2 restoring division of num_bits by N_DBPS, giving quotient q (BITS_W bits) and remainder r (DBPS_W bits). Then go to FIX.
- FIX, 1 cycle:
  - If r==0 and num_bits!=0: sym=q, last=N_DBPS.
  - Otherwise: sym=q+1, last=r. num_bits=0 therefore gives sym=1, last=0.
  - If sym>2^SYM_W-1: n_ofdm_sym=2^SYM_W-1 and sym_sat=1.
  - Register the outputs, set phy_len_valid=1, pulse done, return to IDLE.
- Latency: start sampled at cycle t; done and results visible at t+BITS_W+3; busy high over t+1 .. t+BITS_W+2.
- Abort in LOOKUP, DIV or FIX:
  - Next cycle IDLE, busy=0, no done.
  - phy_len_valid=0; previous n_ofdm_sym and n_bit_in_last_sym are retained.
- Reset mid-operation: every output returns to its reset value on the next edge.
- Input changes after start have no effect; all inputs are consumed from latched copies.

Decomposition:
- Shared package phy_len_pkg:
  - FSM state encoding.
  - Non-HT rate codes and the N_DBPS constant table, with a function dbps_lookup(ht, bw40, code).
  - Maximum-value constants.
- One sub-module, seq_restoring_div:
  - Parameters NUM_W and DEN_W; ports start/done/quotient/remainder; fixed NUM_W-cycle latency.
  - Shared with other timing blocks.

Test Plan:
- Non-HT 6 Mbps: pkt_rate=0x0B, num_bits=822 -> after 23 cycles done=1, n_ofdm_sym=35, n_bit_in_last_sym=6, n_dbps=24, phy_len_valid=1.
- HT20 MCS7: pkt_rate=0x87, ht_bw40=0, num_bits=260 -> n_ofdm_sym=1, last=260 (exact-multiple path). Repeat with num_bits=520 -> n_ofdm_sym=2, last=260.
- HT40 MCS15: pkt_rate=0x8F, ht_bw40=1, num_bits=2182 -> n_dbps=1080, n_ofdm_sym=3, last=22. Also HT20 MCS0 with num_bits=524302 -> n_ofdm_sym=20166, last=12.
- Saturation: 6 Mbps, num_bits=1048575 -> sym_sat=1, n_ofdm_sym=32767, last=15.
- Invalid rate: pkt_rate=0x05 -> done at t+2, rate_err=1, phy_len_valid=0, outputs unchanged (1/130 after reset).
- Abort and overlap:
  - Abort at DIV cycle 5 -> busy=0 next cycle, no done, valid=0.
  - Second start while busy -> ignored; exactly one done, with the first request's results.
